// File: rtl/qam_adc_pkg.sv
// rtl/qam_adc_pkg.sv - shared state encoding and frame layout for the serial ADC reader
package qam_adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } adc_state_e;

    localparam int FRAME_BITS     = 34;
    localparam int CH0_LSB_IDX    = 15;
    localparam int CH1_LSB_IDX    = 31;
    localparam int DATA_W_DEFAULT = 14;

endpackage

// File: rtl/adc_reader_if.sv
// rtl/adc_reader_if.sv - ADC pins plus sample bus of adc_reader
interface adc_reader_if;
    logic        start;
    logic        spi_miso;
    logic        ad_conv;
    logic        spi_sck;
    logic        busy;
    logic [15:0] sample_i;
    logic [15:0] sample_q;
    logic        sample_valid;

    modport master (
        input  start, spi_miso,
        output ad_conv, spi_sck, busy, sample_i, sample_q, sample_valid
    );

    modport slave (
        output start, spi_miso,
        input  ad_conv, spi_sck, busy, sample_i, sample_q, sample_valid
    );
endinterface

// File: rtl/adc_sck_gen.sv
// rtl/adc_sck_gen.sv - spi_sck prescaler with one-cycle rise/fall ticks
module adc_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick
);

    logic [7:0] div_cnt;
    logic       wrap;

    // Ticks mark the clk edge on which sck is about to change.
    assign wrap      = en && (div_cnt == 8'(CLK_DIV - 1));
    assign rise_tick = wrap && !sck;
    assign fall_tick = wrap && sck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            sck     <= !sck;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/adc_reader.sv
// rtl/adc_reader.sv - two-channel serial ADC front-end; ADC_FREE_RUN_EN selects free-running conversions
module adc_reader
    import qam_adc_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int OUT_W   = 16
) (
    input  logic          clk,
    input  logic          rst,
    adc_reader_if.master  bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_CONV  = CONV;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam int CH0_POS = FRAME_BITS - 1 - CH0_LSB_IDX;
    localparam int CH1_POS = FRAME_BITS - 1 - CH1_LSB_IDX;

    logic [1:0]            state;
    logic [8:0]            conv_cnt;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] frame_next;
    logic                  miso_q;
    logic                  shift_pend;
    logic                  sck;
    logic                  rise_tick;
    logic                  fall_tick;
    logic                  frame_end;
    logic [DATA_W-1:0]     ch0_raw;
    logic [DATA_W-1:0]     ch1_raw;
    logic [OUT_W-1:0]      sample_i_q;
    logic [OUT_W-1:0]      sample_q_q;

    adc_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (state == ST_SHIFT),
        .sck       (sck),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    assign frame_end = fall_tick && (bit_cnt == 6'(FRAME_BITS));

    // With CLK_DIV=1 the last bit is still in flight when the frame ends,
    // so the samples are taken from the frame as it will look after this edge.
    assign frame_next = shift_pend ? {shreg[FRAME_BITS-2:0], miso_q} : shreg;
    assign ch0_raw    = frame_next[CH0_POS +: DATA_W];
    assign ch1_raw    = frame_next[CH1_POS +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            conv_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state    <= ST_CONV;
                        conv_cnt <= '0;
                    end
                end
                ST_CONV: begin
                    if (conv_cnt == 9'(2 * CLK_DIV - 1)) begin
                        state <= ST_SHIFT;
                    end else begin
                        conv_cnt <= conv_cnt + 9'd1;
                    end
                end
                ST_SHIFT: begin
                    if (frame_end) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
`ifdef ADC_FREE_RUN_EN
                    state    <= ST_CONV;
                    conv_cnt <= '0;
`else
                    state    <= ST_IDLE;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            miso_q     <= 1'b0;
            shift_pend <= 1'b0;
            sample_i_q <= '0;
            sample_q_q <= '0;
        end else begin
            shift_pend <= rise_tick;
            if (rise_tick) begin
                miso_q <= bus.spi_miso;
            end
            if (state != ST_SHIFT) begin
                bit_cnt <= '0;
            end else if (rise_tick) begin
                bit_cnt <= bit_cnt + 6'd1;
            end
            if (shift_pend) begin
                shreg <= frame_next;
            end
            if (frame_end) begin
                sample_i_q <= {{(OUT_W - DATA_W){ch0_raw[DATA_W-1]}}, ch0_raw};
                sample_q_q <= {{(OUT_W - DATA_W){ch1_raw[DATA_W-1]}}, ch1_raw};
            end
        end
    end

    assign bus.ad_conv      = (state == ST_CONV);
    assign bus.spi_sck      = sck;
    assign bus.busy         = (state != ST_IDLE);
    assign bus.sample_valid = (state == ST_DONE);
    assign bus.sample_i     = sample_i_q;
    assign bus.sample_q     = sample_q_q;

endmodule

// File: tb/tb_adc_reader.sv
// tb/tb_adc_reader.sv - randomized self-checking bench for adc_reader at CLK_DIV=2 and CLK_DIV=1
module tb_adc_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  start_r   = '0;
    logic [1:0]  auto_rand = '0;
    logic [1:0]  ign_r     = '0;
    logic [13:0] ch0_r [2] = '{14'd0, 14'd0};
    logic [13:0] ch1_r [2] = '{14'd0, 14'd0};

    logic [1:0]  busy_w, conv_w, sck_w, valid_w;
    logic [15:0] si_w [2];
    logic [15:0] sq_w [2];

    int valid_cnt  [2] = '{0, 0};
    int last_valid [2] = '{0, 0};
    int prev_valid [2] = '{0, 0};
    int conv_rises [2] = '{0, 0};
    int conv_hi    [2] = '{0, 0};
    int sck_rises  [2] = '{0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit b of the frame, counted MSB first from the start of the transfer.
    function automatic logic frame_bit(input logic [13:0] c0, input logic [13:0] c1,
                                       input logic ign, input int b);
        if (b >= 2 && b <= 15)  return c0[15 - b];
        if (b >= 18 && b <= 31) return c1[31 - b];
        return ign;
    endfunction

    function automatic logic [15:0] exp_sample(input logic [13:0] v);
        int s;
        s = (int'(v) >= 8192) ? int'(v) - 16384 : int'(v);
        return 16'(s);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int D = (g == 0) ? 2 : 1;

        adc_reader_if bus ();
        logic        miso    = 1'b0;
        logic [13:0] cur0    = '0;
        logic [13:0] cur1    = '0;
        logic        cur_ign = 1'b0;
        int          bit_idx = 0;

        assign bus.start    = start_r[g];
        assign bus.spi_miso = miso;
        assign busy_w[g]    = bus.busy;
        assign conv_w[g]    = bus.ad_conv;
        assign sck_w[g]     = bus.spi_sck;
        assign valid_w[g]   = bus.sample_valid;
        assign si_w[g]      = bus.sample_i;
        assign sq_w[g]      = bus.sample_q;

        adc_reader #(.CLK_DIV(D)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // ADC model: latch a frame on the convert pulse, present bit k until the k-th sck rise.
        always @(posedge bus.ad_conv or posedge bus.spi_sck) begin
            if (bus.ad_conv) begin
                conv_rises[g]++;
                if (auto_rand[g]) begin
                    ch0_r[g] = 14'($urandom);
                    ch1_r[g] = 14'($urandom);
                    ign_r[g] = 1'($urandom);
                end
                cur0    = ch0_r[g];
                cur1    = ch1_r[g];
                cur_ign = ign_r[g];
                bit_idx = 0;
                miso    = frame_bit(cur0, cur1, cur_ign, 0);
            end else begin
                sck_rises[g]++;
                #1;
                bit_idx++;
                miso = (bit_idx < 34) ? frame_bit(cur0, cur1, cur_ign, bit_idx) : 1'b0;
            end
        end

        always @(negedge clk) begin
            if (bus.ad_conv) conv_hi[g]++;
            if (bus.sample_valid) begin
                valid_cnt[g]++;
                prev_valid[g] = last_valid[g];
                last_valid[g] = cyc;
                check($sformatf("L%0d_sample_i", g), 32'(bus.sample_i), 32'(exp_sample(cur0)));
                check($sformatf("L%0d_sample_q", g), 32'(bus.sample_q), 32'(exp_sample(cur1)));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input int g, input string tag);
        check($sformatf("L%0d_%s_ad_conv", g, tag), 32'(conv_w[g]), 0);
        check($sformatf("L%0d_%s_sck", g, tag), 32'(sck_w[g]), 0);
        check($sformatf("L%0d_%s_busy", g, tag), 32'(busy_w[g]), 0);
        check($sformatf("L%0d_%s_valid", g, tag), 32'(valid_w[g]), 0);
        check($sformatf("L%0d_%s_sample_i", g, tag), 32'(si_w[g]), 0);
        check($sformatf("L%0d_%s_sample_q", g, tag), 32'(sq_w[g]), 0);
    endtask

    task automatic do_frame(input int g, input logic [13:0] c0, input logic [13:0] c1, input logic ign);
        int d = (g == 0) ? 2 : 1;
        int n0, cr0, hi0, sr0, s, t;
        ch0_r[g] = c0;
        ch1_r[g] = c1;
        ign_r[g] = ign;
        auto_rand[g] = 1'b0;
        n0  = valid_cnt[g];
        cr0 = conv_rises[g];
        hi0 = conv_hi[g];
        sr0 = sck_rises[g];
        start_r[g] = 1'b1;
        s = cyc + 1;
        tick();
        start_r[g] = 1'b0;
        t = 0;
        while (valid_cnt[g] == n0 && t < 200) begin
            tick();
            t++;
            start_r[g] = (t == 25);
        end
        start_r[g] = 1'b0;
        check($sformatf("L%0d_valid_seen", g), 32'(valid_cnt[g] - n0), 1);
        check($sformatf("L%0d_valid_cycle", g), 32'(last_valid[g] - s + 1), 32'(70 * d + 1));
        check($sformatf("L%0d_busy_in_done", g), 32'(busy_w[g]), 1);
        tick();
        check($sformatf("L%0d_busy_after", g), 32'(busy_w[g]), 0);
        check($sformatf("L%0d_conv_pulses", g), 32'(conv_rises[g] - cr0), 1);
        check($sformatf("L%0d_conv_len", g), 32'(conv_hi[g] - hi0), 32'(2 * d));
        check($sformatf("L%0d_sck_rises", g), 32'(sck_rises[g] - sr0), 34);
    endtask

    initial begin
        int n0, cr0, sr0, s, t;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) check_idle_outputs(g, "reset");
        rst = 1'b0;
        tick();

`ifdef ADC_FREE_RUN_EN
        for (int g = 0; g < 2; g++) begin
            int d = (g == 0) ? 2 : 1;
            n0  = valid_cnt[g];
            cr0 = conv_rises[g];
            auto_rand[g] = 1'b1;
            start_r[g] = 1'b1;
            s = cyc + 1;
            tick();
            start_r[g] = 1'b0;
            for (int k = 0; k < 5; k++) begin
                t = 0;
                while (valid_cnt[g] - n0 <= k && t < 200) begin
                    tick();
                    t++;
                    start_r[g] = (t == 30);
                end
                start_r[g] = 1'b0;
                if (k == 0)
                    check($sformatf("L%0d_fr_first", g), 32'(last_valid[g] - s + 1), 32'(70 * d + 1));
                else
                    check($sformatf("L%0d_fr_period", g), 32'(last_valid[g] - prev_valid[g]), 32'(70 * d + 1));
                tick();
                check($sformatf("L%0d_fr_busy", g), 32'(busy_w[g]), 1);
            end
            check($sformatf("L%0d_fr_frames", g), 32'(valid_cnt[g] - n0), 5);
            check($sformatf("L%0d_fr_convs", g), 32'(conv_rises[g] - cr0), 6);
        end
        rst = 1'b1;
        tick();
        for (int g = 0; g < 2; g++) check_idle_outputs(g, "fr_stop");
`else
        do_frame(0, 14'h1FFF, 14'h2000, 1'b0);
        check("L0_pos_full_i", 32'(si_w[0]), 32'h1FFF);
        check("L0_neg_full_q", 32'(sq_w[0]), 32'hE000);

        do_frame(1, 14'h3FFF, 14'h0001, 1'b0);
        check("L1_minus_one_i", 32'(si_w[1]), 32'hFFFF);
        check("L1_plus_one_q", 32'(sq_w[1]), 32'h0001);

        do_frame(0, 14'h0000, 14'h0000, 1'b1);
        check("L0_ignored_i", 32'(si_w[0]), 32'h0000);
        check("L0_ignored_q", 32'(sq_w[0]), 32'h0000);

        for (int i = 0; i < 6; i++) begin
            for (int g = 0; g < 2; g++) begin
                do_frame(g, 14'($urandom), 14'($urandom), 1'($urandom));
            end
        end

        // start held high: back-to-back frames at the minimum period
        n0  = valid_cnt[0];
        cr0 = conv_rises[0];
        auto_rand[0] = 1'b1;
        start_r[0] = 1'b1;
        t = 0;
        while (valid_cnt[0] - n0 < 3 && t < 600) begin
            tick();
            t++;
        end
        start_r[0] = 1'b0;
        check("L0_held_frames", 32'(valid_cnt[0] - n0), 3);
        check("L0_held_period", 32'(last_valid[0] - prev_valid[0]), 142);
        tick();
        tick();
        check("L0_held_idle", 32'(busy_w[0]), 0);
        check("L0_held_convs", 32'(conv_rises[0] - cr0), 3);
        auto_rand[0] = 1'b0;

        // reset in the middle of a frame
        ch0_r[0] = 14'($urandom);
        ch1_r[0] = 14'($urandom);
        n0  = valid_cnt[0];
        sr0 = sck_rises[0];
        start_r[0] = 1'b1;
        tick();
        start_r[0] = 1'b0;
        t = 0;
        while (sck_rises[0] - sr0 < 20 && t < 5000) begin
            #1;
            t++;
        end
        check("L0_rst_reached_rise20", 32'(sck_rises[0] - sr0), 20);
        rst = 1'b1;
        #1;
        check_idle_outputs(0, "midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (200) tick();
        check("L0_rst_no_valid", 32'(valid_cnt[0] - n0), 0);
        check("L0_rst_idle", 32'(busy_w[0]), 0);
        do_frame(0, 14'($urandom), 14'($urandom), 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
